// File: rtl/auto_cmd_gen.sv
// auto_cmd_gen: timer/step/burst driven CMD_ADVANCE source that coalesces ticks under backpressure
`ifndef CMD_ADVANCE
`define CMD_ADVANCE 3'd1
`endif
module auto_cmd_gen #(
  parameter int TIMER_W   = 32,
  parameter int NUM_RATES = 7,
  parameter int BASE_BIT  = 25,
  parameter int RATE_STEP = 2,
  parameter int ARG_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic [NUM_RATES-1:0] rate_sel,
  input  logic                 step,
  input  logic                 burst_start,
  input  logic [ARG_W-1:0]     burst_len,
  output logic [2:0]           cmd,
  output logic [ARG_W-1:0]     cmd_arg0,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic                 busy,
  output logic                 burst_done,
  output logic                 sat
);
  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [NUM_RATES-1:0] pick;
  logic                 raw_tick, tick, hs, lost, unused_timer;
  logic                 valid_q, valid_d, sat_q, sat_d, done_q, done_d, state_q, state_d;
  logic [ARG_W-1:0]     cnt_q, cnt_d, rem_q, rem_d;
  assign timer_d = timer_q + 1'b1;
  assign unused_timer = ^{timer_q, timer_d};
  // a rate fires only if it is the highest requested one and its bit rises this cycle
  for (genvar g = 0; g < NUM_RATES; g++) begin : g_rate
    assign pick[g] = rate_sel[g] & ((rate_sel >> (g + 1)) == '0)
                   & ~timer_q[BASE_BIT - RATE_STEP*g] & timer_d[BASE_BIT - RATE_STEP*g];
  end
  assign raw_tick = |pick;
  assign hs = valid_q & cmd_ready;
  assign tick = mode == 2'b01 ? raw_tick :
                mode == 2'b10 ? step :
                mode == 2'b11 ? raw_tick & (state_q == RUN) & (rem_q != '0) : 1'b0;
  assign lost = tick & valid_q & ~hs & (cnt_q == '1);
  always_comb begin
    valid_d = tick | (valid_q & ~hs);
    cnt_d   = tick ? ((hs | ~valid_q) ? ARG_W'(1) : (lost ? cnt_q : cnt_q + 1'b1))
                   : (hs ? '0 : cnt_q);
    sat_d   = sat_q | lost;
  end
  // a burst only finishes once every generation it produced has been accepted
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    if (state_q == RUN) begin
      if (mode != 2'b11) begin
        state_d = IDLE;
        rem_d   = '0;
      end else if (tick) begin
        rem_d = rem_q - 1'b1;
      end else if (rem_q == '0 && (!valid_q || hs)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (mode == 2'b11 && burst_start) begin
      if (burst_len != '0) begin
        state_d = RUN;
        rem_d   = burst_len;
      end else begin
        done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '1;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      timer_q <= timer_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end
  assign cmd        = `CMD_ADVANCE;
  assign cmd_arg0   = cnt_q;
  assign cmd_valid  = valid_q;
  assign busy       = state_q == RUN;
  assign burst_done = done_q;
  assign sat        = sat_q;
endmodule

// File: tb/tb_auto_cmd_gen.sv
// tb_auto_cmd_gen: directed stimulus with an outstanding-generations model checked every cycle
module tb_auto_cmd_gen;
  localparam logic [2:0] CMD_ADV = 3'd1;
  localparam longint MAXV = 64'hFFFF_FFFF;
  logic clk, reset, step, burst_start, cmd_ready, cmd_valid, busy, burst_done, sat;
  logic [1:0] mode;
  logic [2:0] rate_sel, cmd;
  logic [31:0] burst_len, cmd_arg0;
  logic [1:0] s_mode, s_arg;
  logic [2:0] s_sel, s_cmd;
  logic s_ready, s_valid, s_busy, s_done, s_sat;
  int checks = 0, errors = 0, cyc = 0;
  longint hs_cnt = 0, hs_sum = 0, done_cnt = 0, last_arg = 0;
  int m_timer;
  longint m_cnt, m_cnt_n, m_left;
  bit m_sat, m_busy, m_done, m_hs, m_raw, m_t, m_lost;

  auto_cmd_gen #(.TIMER_W(8), .NUM_RATES(3), .BASE_BIT(4), .RATE_STEP(1), .ARG_W(32)) dut (
    .clk(clk), .reset(reset), .mode(mode), .rate_sel(rate_sel), .step(step),
    .burst_start(burst_start), .burst_len(burst_len), .cmd(cmd), .cmd_arg0(cmd_arg0),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .busy(busy), .burst_done(burst_done), .sat(sat));

  auto_cmd_gen #(.TIMER_W(8), .NUM_RATES(3), .BASE_BIT(4), .RATE_STEP(1), .ARG_W(2)) dut_s (
    .clk(clk), .reset(reset), .mode(s_mode), .rate_sel(s_sel), .step(1'b0),
    .burst_start(1'b0), .burst_len(2'b00), .cmd(s_cmd), .cmd_arg0(s_arg),
    .cmd_valid(s_valid), .cmd_ready(s_ready), .busy(s_busy), .burst_done(s_done), .sat(s_sat));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // rate k uses timer bit 4-k; it fires when the timer sits one below a multiple of 2^(b) within a 2^(b+1) period
  function automatic bit tick_at(input int t, input logic [2:0] sel);
    for (int k = 2; k >= 0; k--)
      if (sel[k]) return (t % (1 << (5 - k))) == (1 << (4 - k)) - 1;
    return 0;
  endfunction

  always_comb begin
    m_hs    = m_cnt != 0 && cmd_ready;
    m_raw   = tick_at(m_timer, rate_sel);
    m_t     = mode == 2'b01 ? m_raw : mode == 2'b10 ? step :
              mode == 2'b11 ? (m_raw && m_busy && m_left != 0) : 1'b0;
    m_lost  = !m_hs && m_t && m_cnt == MAXV;
    m_cnt_n = m_hs ? longint'(m_t) : (m_lost ? m_cnt : m_cnt + longint'(m_t));
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_timer <= 255; m_cnt <= 0; m_sat <= 0; m_busy <= 0; m_left <= 0; m_done <= 0;
    end else begin
      m_timer <= (m_timer + 1) % 256;
      m_cnt   <= m_cnt_n;
      m_sat   <= m_sat || m_lost;
      m_done  <= 0;
      if (m_busy) begin
        if (mode != 2'b11) begin
          m_busy <= 0; m_left <= 0;
        end else if (m_t) begin
          m_left <= m_left - 1;
        end else if (m_left == 0 && m_cnt_n == 0) begin
          m_busy <= 0; m_done <= 1;
        end
      end else if (mode == 2'b11 && burst_start) begin
        if (burst_len != 0) begin
          m_busy <= 1; m_left <= longint'(burst_len);
        end else begin
          m_done <= 1;
        end
      end
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc <= 0; hs_cnt <= 0; hs_sum <= 0; done_cnt <= 0; last_arg <= 0;
    end else begin
      cyc <= cyc + 1;
      if (cmd_valid && cmd_ready) begin
        hs_cnt <= hs_cnt + 1; hs_sum <= hs_sum + longint'(cmd_arg0); last_arg <= longint'(cmd_arg0);
      end
      if (burst_done) done_cnt <= done_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("valid", longint'(cmd_valid), longint'(m_cnt != 0));
      chk("arg0", longint'(cmd_arg0), m_cnt);
      chk("busy", longint'(busy), longint'(m_busy));
      chk("burst_done", longint'(burst_done), longint'(m_done));
      chk("sat", longint'(sat), longint'(m_sat));
      if (cmd_valid) chk("cmd", longint'(cmd), longint'(CMD_ADV));
    end
  end

  task automatic wait_valid(input int n, input string nm);
    bit ok = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (cmd_valid) begin ok = 1; break; end
    end
    chk(nm, longint'(ok), 1);
  endtask

  initial begin
    longint h0, s0, d0;
    bit ok;
    reset = 1; mode = 0; rate_sel = 0; step = 0; burst_start = 0; burst_len = 0; cmd_ready = 1;
    s_mode = 0; s_sel = 3'b100; s_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", longint'(cmd_valid), 0);
    chk("rst_arg0", longint'(cmd_arg0), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(burst_done), 0);
    chk("rst_sat", longint'(sat), 0);
    mode = 2'b01; rate_sel = 3'b001; reset = 0;
    wait_valid(40, "first_valid_wait");
    chk("first_valid_cycle", longint'(cyc), 17);
    chk("first_arg0", longint'(cmd_arg0), 1);
    @(negedge clk);
    wait_valid(40, "second_valid_wait");
    chk("period_cycle", longint'(cyc), 49);
    @(negedge clk);
    chk("one_cycle_valid", longint'(cmd_valid), 0);
    rate_sel = 3'b111; cmd_ready = 0;
    repeat (40) @(negedge clk);
    chk("stall_valid", longint'(cmd_valid), 1);
    chk("coalesced_arg0", longint'(cmd_arg0), 5);
    cmd_ready = 1;
    @(negedge clk);
    cmd_ready = 0;
    chk("drain_valid", longint'(cmd_valid), 0);
    chk("drain_arg", last_arg, 5);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cmd_valid && tick_at(m_timer, rate_sel)) begin ok = 1; break; end
    end
    chk("tick_hs_wait", longint'(ok), 1);
    cmd_ready = 1;
    @(negedge clk);
    chk("b2b_valid", longint'(cmd_valid), 1);
    chk("b2b_arg0", longint'(cmd_arg0), 1);
    mode = 2'b10;
    repeat (2) @(negedge clk);
    h0 = hs_cnt; s0 = hs_sum;
    for (int i = 0; i < 3; i++) begin
      step = 1; @(negedge clk); step = 0;
      repeat (3) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("step_cmds", hs_cnt - h0, 3);
    chk("step_sum", hs_sum - s0, 3);
    cmd_ready = 0;
    step = 1; @(negedge clk); step = 0;
    repeat (2) @(negedge clk);
    step = 1; @(negedge clk); step = 0;
    chk("step_coalesce", longint'(cmd_arg0), 2);
    cmd_ready = 1;
    @(negedge clk);
    chk("step_drain", longint'(cmd_valid), 0);
    mode = 2'b11; rate_sel = 3'b100; burst_len = 3;
    @(negedge clk);
    h0 = hs_cnt; s0 = hs_sum; d0 = done_cnt;
    burst_start = 1; @(negedge clk); burst_start = 0;
    chk("burst_busy", longint'(busy), 1);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (burst_done) begin ok = 1; break; end
    end
    chk("burst_wait", longint'(ok), 1);
    chk("burst_sum", hs_sum - s0, 3);
    chk("burst_cmds", hs_cnt - h0, 3);
    @(negedge clk);
    chk("burst_idle", longint'(busy), 0);
    chk("burst_done_pulses", done_cnt - d0, 1);
    burst_len = 0; h0 = hs_cnt;
    burst_start = 1; @(negedge clk); burst_start = 0;
    chk("zero_done", longint'(burst_done), 1);
    chk("zero_busy", longint'(busy), 0);
    repeat (10) @(negedge clk);
    chk("zero_cmds", hs_cnt - h0, 0);
    mode = 2'b00; burst_len = 5;
    burst_start = 1; @(negedge clk); burst_start = 0;
    chk("start_ignored", longint'(busy), 0);
    mode = 2'b11; burst_len = 10; cmd_ready = 0;
    @(negedge clk);
    burst_start = 1; @(negedge clk); burst_start = 0;
    d0 = done_cnt; h0 = hs_cnt;
    wait_valid(20, "abort_valid_wait");
    mode = 2'b00;
    @(negedge clk);
    chk("abort_busy", longint'(busy), 0);
    chk("abort_valid", longint'(cmd_valid), 1);
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    cmd_ready = 1;
    @(negedge clk);
    chk("abort_delivered", hs_cnt - h0, 1);
    chk("abort_valid_clear", longint'(cmd_valid), 0);
    mode = 2'b01; rate_sel = 3'b100; cmd_ready = 0; s_mode = 2'b01;
    repeat (24) @(negedge clk);
    chk("sat_arg_at3", longint'(s_arg), 3);
    chk("sat_not_yet", longint'(s_sat), 0);
    repeat (16) @(negedge clk);
    chk("sat_arg_held", longint'(s_arg), 3);
    chk("sat_set", longint'(s_sat), 1);
    chk("sat_valid", longint'(s_valid), 1);
    chk("main_stalled", longint'(cmd_valid), 1);
    #2 reset = 1;
    #1;
    chk("rst_mid_valid", longint'(cmd_valid), 0);
    chk("rst_mid_arg0", longint'(cmd_arg0), 0);
    chk("rst_mid_sat", longint'(sat), 0);
    chk("rst_mid_s_valid", longint'(s_valid), 0);
    chk("rst_mid_s_arg", longint'(s_arg), 0);
    chk("rst_mid_s_sat", longint'(s_sat), 0);
    @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/auto_cmd_gen.md
Name: auto_cmd_gen

Overview:
- Parametrised auto-advance command source for the life engine command port.
- Generates `CMD_ADVANCE commands at one of NUM_RATES power-of-two rates, derived from a free-running timer.
- Three modes: continuous, manual single-step and counted burst.
- Unlike the previous generator it honours cmd_ready backpressure. Ticks that arrive while a command is stalled are coalesced into the generation count carried in cmd_arg0, so no generations are lost.

Parameters:
- TIMER_W, 32, free-running timer width.
- NUM_RATES, 7, number of selectable rates.
- BASE_BIT, 25, timer bit for rate 0 (slowest).
- RATE_STEP, 2, bit spacing between adjacent rates. Legal only if BASE_BIT - RATE_STEP*(NUM_RATES-1) >= 0 and BASE_BIT < TIMER_W.
- ARG_W, 32, width of the generation count and burst length.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- mode  in  2  00 off, 01 continuous, 10 step, 11 burst.
- rate_sel  in  NUM_RATES  rate request; the highest set index wins; all zero means no timer ticks.
- step  in  1  single-cycle pulse (already debounced); advances one generation in step mode.
- burst_start  in  1  single-cycle pulse; starts a burst in burst mode.
- burst_len  in  ARG_W  generations per burst; sampled on burst_start.
- cmd  out  3  always `CMD_ADVANCE (from command.vh).
- cmd_arg0  out  ARG_W  generations to advance; 0 when cmd_valid=0.
- cmd_valid  out  1  command offered.
- cmd_ready  in  1  consumer accepts; handshake = cmd_valid & cmd_ready.
- busy  out  1  burst in progress.
- burst_done  out  1  one-cycle pulse when a burst completes.
- sat  out  1  sticky: pending count saturated; cleared only by reset.

Behaviour:
- Reset values:
  - timer = all ones.
  - cmd_valid=0, pending count=0, cmd_arg0=0.
  - busy=0, burst_done=0, sat=0, burst remaining=0.
- Timer:
  - timer_next = timer+1, wraps modulo 2^TIMER_W.
  - Rate k raw tick in a cycle when bit b=BASE_BIT-RATE_STEP*k is 0 in timer and 1 in timer_next; period 2^(b+1) cycles.
  - rate_sel changes take effect combinationally; the timer is never reset by rate or mode changes.
- Effective tick (combinational):
  - mode 01: raw tick.
  - mode 10: step. Raw ticks are ignored.
  - mode 11: raw tick & busy & remaining!=0.
  - mode 00: none.
- Pending register update, with hs = cmd_valid & cmd_ready:
  - tick & !cmd_valid: valid<=1, count<=1.
  - tick & cmd_valid & !hs: count<=count+1, saturating at 2^ARG_W-1; sat<=1 when an increment is lost to saturation.
  - tick & hs: valid<=1, count<=1 (new command follows back-to-back).
  - !tick & hs: valid<=0, count<=0.
  - otherwise hold.
- Latency:
  - Tick in cycle T gives cmd_valid=1 in cycle T+1.
  - cmd_valid never drops and cmd_arg0 never decreases without a handshake, including across mode changes to 00.
- Burst FSM, states IDLE/RUN:
  - IDLE, mode 11, burst_start, burst_len!=0: remaining<=burst_len, busy<=1, go to RUN.
  - IDLE, mode 11, burst_start, burst_len=0: burst_done=1 in the next cycle, stay IDLE, no command.
  - RUN: each effective tick decrements remaining.
  - RUN exits to IDLE when remaining==0 and (!cmd_valid or hs), with no tick that cycle. busy<=0 and burst_done=1 in the next cycle.
  - burst_start while busy: ignored.
  - burst_start outside mode 11: ignored.
  - Mode leaves 11 while RUN: remaining<=0, busy<=0, go to IDLE, no burst_done; the already pending command is still delivered.
  - Total generations delivered by a completed burst (sum of accepted cmd_arg0) == burst_len exactly.
- reset asserted mid-operation: all state returns to reset values immediately; pending generations are discarded.

Test Plan (bench params TIMER_W=8, BASE_BIT=4, RATE_STEP=1, NUM_RATES=3):
- Continuous rate 0, cmd_ready=1, mode 01, rate_sel=001 from reset release:
  - first cmd_valid on the cycle after timer=0x0F, i.e. 17 cycles after the first clock edge;
  - then one-cycle valid every 32 cycles, cmd_arg0=1, cmd=`CMD_ADVANCE.
- Priority and backpressure:
  - rate_sel=111 (bit 2, period 8) with cmd_ready=0 for 40 cycles: cmd_valid held and cmd_arg0 counts 1→5.
  - Then cmd_ready=1 for one cycle: handshake with arg0=5, then valid=0.
- Tick on handshake cycle:
  - release cmd_ready exactly on a tick cycle: next cycle cmd_valid=1, arg0=1, no gap.
- Step mode:
  - mode 10, three step pulses 4 cycles apart, cmd_ready=1: three commands, arg0=1 each, none from the timer.
  - Two steps with cmd_ready=0: one command with arg0=2.
- Burst:
  - mode 11, burst_len=3, rate 2, cmd_ready=1: exactly 3 commands, busy high throughout, one burst_done pulse.
  - burst_len=0: burst_done one cycle after start, no command.
  - Switch to mode 00 mid-burst: busy falls, no burst_done, pending command still handshakes.
- Saturation and reset:
  - ARG_W=2 override, cmd_ready=0, 5 ticks: arg0=3, sat=1.
  - Assert reset mid-stall: cmd_valid, arg0, sat all 0 in the same cycle.
